// File: rtl/stream_arbiter_rr.sv
// -----------------------------------------------------------------------------
// stream_arbiter_rr
//
// N-input packet arbiter in front of a shared downstream link. At a packet
// boundary the valid input with the highest QoS wins. Ties are broken
// round-robin, starting from the stream after the previous winner. The grant
// is then held until the beat carrying last is accepted, so packets are never
// interleaved. The output stream is fully registered and sustains one beat per
// cycle under back-to-back traffic.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   s_data_i   per-stream beat data   (unpacked [STREAM_COUNT-1:0])
//   s_qos_i    per-stream QoS; larger value means higher priority
//   s_last_i   per-stream last-beat-of-packet flag
//   s_valid_i  per-stream beat valid
//   s_ready_o  per-stream ready; one-hot or zero
//   m_data_o   registered output data
//   m_qos_o    registered QoS of the output beat
//   m_id_o     registered source stream index of the output beat
//   m_last_o   registered last flag of the output beat
//   m_valid_o  registered output valid
//   m_ready_i  downstream ready
// -----------------------------------------------------------------------------
module stream_arbiter_rr #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 4,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i  [STREAM_COUNT-1:0],
    input  logic [T_QOS__WIDTH-1:0] s_qos_i   [STREAM_COUNT-1:0],
    input  logic [STREAM_COUNT-1:0] s_last_i,
    input  logic [STREAM_COUNT-1:0] s_valid_i,
    output logic [STREAM_COUNT-1:0] s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_QOS__WIDTH-1:0] m_qos_o,
    output logic [T_ID___WIDTH-1:0] m_id_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // (base + ofs) mod STREAM_COUNT. ofs never exceeds STREAM_COUNT-1, so a
    // single conditional subtract is enough, and one extra bit holds the sum.
    function automatic logic [T_ID___WIDTH-1:0] wrap_add(
        input logic [T_ID___WIDTH-1:0] base,
        input int unsigned             ofs
    );
        logic [T_ID___WIDTH:0] sum;
        logic [T_ID___WIDTH:0] lim;
        logic [T_ID___WIDTH:0] res;
        sum = {1'b0, base} + (T_ID___WIDTH+1)'(ofs);
        lim = (T_ID___WIDTH+1)'(STREAM_COUNT);
        res = (sum >= lim) ? (sum - lim) : sum;
        return res[T_ID___WIDTH-1:0];
    endfunction

    state_t                    state_r;
    state_t                    state_nx_s;
    logic [T_ID___WIDTH-1:0]   gnt_id_r;
    logic [T_ID___WIDTH-1:0]   gnt_id_nx_s;
    logic [T_ID___WIDTH-1:0]   rr_ptr_r;
    logic [T_ID___WIDTH-1:0]   rr_ptr_nx_s;

    logic [T_QOS__WIDTH-1:0]   max_q_s;
    logic                      any_valid_s;
    logic [STREAM_COUNT-1:0]   cand_s;
    logic [T_ID___WIDTH-1:0]   winner_s;

    logic [T_ID___WIDTH-1:0]   src_s;
    logic                      grant_en_s;
    logic                      slot_free_s;
    logic                      accept_s;
    logic                      src_last_s;
    logic [STREAM_COUNT-1:0]   ready_vec_s;

    logic [T_DATA_WIDTH-1:0]   m_data_r;
    logic [T_QOS__WIDTH-1:0]   m_qos_r;
    logic [T_ID___WIDTH-1:0]   m_id_r;
    logic                      m_last_r;
    logic                      m_valid_r;

    // Highest QoS among the valid streams, and whether any stream is valid.
    always_comb begin
        max_q_s     = '0;
        any_valid_s = 1'b0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            any_valid_s = any_valid_s | s_valid_i[i];
            max_q_s     = (s_valid_i[i] && (s_qos_i[i] > max_q_s)) ? s_qos_i[i] : max_q_s;
        end
    end

    // Candidate mask: valid streams sitting at the maximum QoS.
    always_comb begin
        cand_s = '0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            cand_s[i] = s_valid_i[i] && (s_qos_i[i] == max_q_s);
        end
    end

    // Round-robin scan from rr_ptr. The scan runs from the far end back
    // towards rr_ptr, so the last hit kept is the first candidate at or after
    // rr_ptr.
    always_comb begin
        winner_s = rr_ptr_r;
        for (int k = STREAM_COUNT - 1; k >= 0; k--) begin
            winner_s = cand_s[wrap_add(rr_ptr_r, unsigned'(k))] ? wrap_add(rr_ptr_r, unsigned'(k)) : winner_s;
        end
    end

    // Source selection and handshake. While locked, the granted stream owns the
    // slot even when its valid is low, so no other stream can slip in.
    always_comb begin
        src_s       = winner_s;
        grant_en_s  = 1'b0;
        ready_vec_s = '0;
        if (state_r == ST_LOCK) begin
            src_s      = gnt_id_r;
            grant_en_s = 1'b1;
        end else begin
            src_s      = winner_s;
            grant_en_s = any_valid_s;
        end
        slot_free_s        = !m_valid_r || m_ready_i;
        src_last_s         = s_last_i[src_s];
        accept_s           = slot_free_s && grant_en_s && s_valid_i[src_s];
        ready_vec_s[src_s] = slot_free_s && grant_en_s && rst_n;
    end

    assign s_ready_o = ready_vec_s;

    // Next-state logic for the packet lock, the grant id and the round-robin pointer.
    always_comb begin
        state_nx_s  = state_r;
        gnt_id_nx_s = gnt_id_r;
        rr_ptr_nx_s = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    rr_ptr_nx_s = wrap_add(winner_s, 32'd1);
                    if (!src_last_s) begin
                        state_nx_s  = ST_LOCK;
                        gnt_id_nx_s = winner_s;
                    end else begin
                        state_nx_s  = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (accept_s && src_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_LOCK;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            gnt_id_r <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_nx_s;
            gnt_id_r <= gnt_id_nx_s;
            rr_ptr_r <= rr_ptr_nx_s;
        end
    end

    // Output slot: load on an accepted beat, drain when the downstream takes
    // the beat, otherwise hold so the beat stays stable under a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r  <= '0;
            m_qos_r   <= '0;
            m_id_r    <= '0;
            m_last_r  <= 1'b0;
            m_valid_r <= 1'b0;
        end else if (accept_s) begin
            m_data_r  <= s_data_i[src_s];
            m_qos_r   <= s_qos_i[src_s];
            m_id_r    <= src_s;
            m_last_r  <= src_last_s;
            m_valid_r <= 1'b1;
        end else if (m_ready_i) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign m_data_o  = m_data_r;
    assign m_qos_o   = m_qos_r;
    assign m_id_o    = m_id_r;
    assign m_last_o  = m_last_r;
    assign m_valid_o = m_valid_r;

endmodule

// File: tb/tb_stream_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_arbiter_rr
//
// Directed bench for stream_arbiter_rr (4 streams). Each stream has a queue of
// beats that is presented on its input. Every beat seen accepted at an input
// handshake is pushed to a scoreboard together with its source index, and every
// beat transferred at the output is popped and compared against it. Directed
// phases also queue the grant order they expect. The random phase checks that
// packets are unbroken and that each source stays in order.
// -----------------------------------------------------------------------------
module tb_stream_arbiter_rr;

    localparam int N = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] qos;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic [3:0] qos;
        logic       last;
    } obeat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   s_data_i  [N-1:0];
    logic [3:0]   s_qos_i   [N-1:0];
    logic [N-1:0] s_last_i;
    logic [N-1:0] s_valid_i;
    logic [N-1:0] s_ready_o;
    logic [7:0]   m_data_o;
    logic [3:0]   m_qos_o;
    logic [1:0]   m_id_o;
    logic         m_last_o;
    logic         m_valid_o;
    logic         m_ready_i;

    beat_t        src_q [N][$];
    obeat_t       sb_q[$];
    int unsigned  exp_id_q[$];
    int           cyc;
    int           start_at [N];
    int           stall_from;
    int           stall_len;
    bit           rand_mode;
    logic [7:0]   held_data;
    bit           in_pkt;
    logic [1:0]   cur_id;
    int           next_seq [N];
    int           tot_seq [N];
    int           n_vec;
    int           n_err;

    stream_arbiter_rr #(
        .T_DATA_WIDTH(8),
        .T_QOS__WIDTH(4),
        .STREAM_COUNT(N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data_i),
        .s_qos_i   (s_qos_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_qos_o   (m_qos_o),
        .m_id_o    (m_id_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len, input logic [3:0] qos, input logic [7:0] base);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = base + 8'(j);
            b.qos  = qos;
            b.last = (j == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && cyc >= start_at[i] && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                s_valid_i[i] = 1'b1;
                s_data_i[i]  = src_q[i][0].data;
                s_qos_i[i]   = src_q[i][0].qos;
                s_last_i[i]  = src_q[i][0].last;
            end else begin
                s_valid_i[i] = 1'b0;
                s_data_i[i]  = 8'h00;
                s_qos_i[i]   = 4'h0;
                s_last_i[i]  = 1'b0;
            end
        end
        m_ready_i = !(cyc >= stall_from && cyc < stall_from + stall_len)
                    && (!rand_mode || $urandom_range(0, 3) != 0);
    endtask

    function automatic bit drained();
        bit d;
        d = (sb_q.size() == 0) && !m_valid_o;
        for (int i = 0; i < N; i++) begin
            d = d && (src_q[i].size() == 0);
        end
        return d;
    endfunction

    // One clock cycle: drive, check at the falling edge, advance after the rising edge.
    task automatic tick();
        logic [N-1:0] acc;
        obeat_t       e;
        int unsigned  eid;
        bit           stalled;
        drive_inputs();
        stalled = (cyc >= stall_from && cyc < stall_from + stall_len);
        @(negedge clk);
        check("ready_onehot", 32'($countones(s_ready_o) <= 1), 32'd1);
        if (m_valid_o && m_ready_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", m_valid_o, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_id",   m_id_o,   e.id);
                check("out_data", m_data_o, e.data);
                check("out_qos",  m_qos_o,  e.qos);
                check("out_last", m_last_o, e.last);
            end
            if (exp_id_q.size() > 0) begin
                eid = exp_id_q.pop_front();
                check("grant_order", m_id_o, eid);
            end
            if (rand_mode) begin
                if (in_pkt) check("t6_no_interleave", m_id_o, cur_id);
                check("t6_src_tag",   m_data_o[7:6], m_id_o);
                check("t6_src_order", m_data_o[5:0], next_seq[m_id_o]);
                next_seq[m_id_o]++;
                in_pkt = !m_last_o;
                cur_id = m_id_o;
            end
        end
        if (stalled) begin
            if (cyc == stall_from) begin
                held_data = m_data_o;
            end else begin
                check("stall_hold", m_data_o, held_data);
            end
            check("stall_ready", s_ready_o, 32'd0);
            check("stall_valid", m_valid_o, 32'd1);
        end
        acc = s_valid_i & s_ready_o;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                e.id   = 2'(i);
                e.data = src_q[i][0].data;
                e.qos  = src_q[i][0].qos;
                e.last = src_q[i][0].last;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        cyc++;
    endtask

    task automatic run(input string tag, input int budget, input int exp_ticks);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!drained() && n < budget);
        check({tag, "_drained"}, 32'(drained()), 32'd1);
        if (exp_ticks > 0) check({tag, "_ticks"}, n, exp_ticks);
        check({tag, "_order_left"}, exp_id_q.size(), 32'd0);
    endtask

    initial begin
        logic [3:0] q1 [N];
        int         seq;
        int         len;
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        stall_from = -100;
        stall_len  = 0;
        rand_mode  = 1'b0;
        in_pkt     = 1'b0;
        cur_id     = 2'd0;
        held_data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            start_at[i]  = 0;
            next_seq[i]  = 0;
            tot_seq[i]   = 0;
            s_data_i[i]  = 8'h5A;
            s_qos_i[i]   = 4'h3;
        end
        s_last_i  = '1;
        s_valid_i = '1;
        m_ready_i = 1'b1;
        rst_n     = 1'b0;

        // Reset state, with all streams requesting.
        #2;
        check("rst_ready", s_ready_o, 32'd0);
        check("rst_valid", m_valid_o, 32'd0);
        check("rst_data",  m_data_o,  32'd0);
        check("rst_qos",   m_qos_o,   32'd0);
        check("rst_id",    m_id_o,    32'd0);
        check("rst_last",  m_last_o,  32'd0);
        s_valid_i = '0;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", m_valid_o, 32'd0);

        // QoS 7 pair alternates; lower-QoS streams only get served afterwards.
        q1[0] = 4'd3; q1[1] = 4'd7; q1[2] = 4'd7; q1[3] = 4'd2;
        for (int k = 0; k < 6; k++) begin
            add_pkt(1, 1, q1[1], 8'(8'h10 + k));
            add_pkt(2, 1, q1[2], 8'(8'h20 + k));
            exp_id_q.push_back(1);
            exp_id_q.push_back(2);
        end
        add_pkt(0, 1, q1[0], 8'h01);
        add_pkt(3, 1, q1[3], 8'h31);
        exp_id_q.push_back(0);
        exp_id_q.push_back(3);
        run("t1", 100, 15);

        // Equal QoS: pure round robin, one beat per cycle.
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < N; s++) begin
                add_pkt(s, 1, 4'd5, 8'(8'h80 + s * 16 + k));
                exp_id_q.push_back(s);
            end
        end
        run("t2", 100, 13);

        // Locked packet ignores a higher-QoS arrival; single valid QoS-0 stream still wins.
        add_pkt(2, 4, 4'd1, 8'h20);
        start_at[0] = cyc + 1;
        add_pkt(0, 1, 4'd15, 8'h0F);
        start_at[3] = cyc + 1;
        add_pkt(3, 1, 4'd0, 8'h3C);
        for (int k = 0; k < 4; k++) exp_id_q.push_back(2);
        exp_id_q.push_back(0);
        exp_id_q.push_back(3);
        run("t3", 100, 7);

        // Downstream stall of 5 cycles in the middle of a packet.
        add_pkt(1, 6, 4'd2, 8'hA0);
        start_at[3] = cyc + 2;
        add_pkt(3, 2, 4'd9, 8'hB0);
        stall_from = cyc + 2;
        stall_len  = 5;
        for (int k = 0; k < 6; k++) exp_id_q.push_back(1);
        exp_id_q.push_back(3);
        exp_id_q.push_back(3);
        run("t4", 100, 14);
        stall_from = -100;
        stall_len  = 0;

        // Asynchronous reset while locked drops the packet and restarts arbitration.
        add_pkt(1, 4, 4'd3, 8'h51);
        tick();
        tick();
        check("t5_pre_valid", m_valid_o, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", m_valid_o, 32'd0);
        check("t5_rst_data",  m_data_o,  32'd0);
        check("t5_rst_qos",   m_qos_o,   32'd0);
        check("t5_rst_id",    m_id_o,    32'd0);
        check("t5_rst_last",  m_last_o,  32'd0);
        check("t5_rst_ready", s_ready_o, 32'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb_q.delete();
        exp_id_q.delete();
        drive_inputs();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rel_valid", m_valid_o, 32'd0);
        for (int s = 0; s < N; s++) begin
            add_pkt(s, 1, 4'd4, 8'(8'hC0 + s));
            exp_id_q.push_back(s);
        end
        run("t5", 100, 5);

        // Random traffic with valid gaps and downstream back-pressure.
        rand_mode = 1'b1;
        in_pkt    = 1'b0;
        for (int s = 0; s < N; s++) begin
            seq = 0;
            for (int p = 0; p < 3; p++) begin
                len = $urandom_range(1, 4);
                add_pkt(s, len, 4'($urandom_range(0, 15)), 8'(s * 64 + seq));
                seq += len;
            end
            tot_seq[s] = seq;
        end
        run("t6", 2000, 0);
        check("t6_pkt_closed", 32'(in_pkt), 32'd0);
        for (int s = 0; s < N; s++) begin
            check("t6_src_count", next_seq[s], tot_seq[s]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
